apple_length_manager: RTL

Spawns and tracks the apple, detects when the snake head eats it, and owns the snake length and score. It sits directly downstream of the snake position controller and consumes the head coordinate (the low 10 bits of each position bus). It feeds the controller's `length`, `x_apple` and `y_apple` inputs, and also drives the renderer.

---
 rtl/apple_length_manager.sv | 106 ++++++++++
 1 files changed

// File: rtl/apple_length_manager.sv
// Apple spawn/eat tracker: owns apple position, snake length and score.
// Optional APPLE_KEEPOUT_EN rejects spawns inside the central obstacle block.
module apple_length_manager #(
  parameter int          GRID        = 10,
  parameter int          INIT_LENGTH = 3,
  parameter int          MAX_LENGTH  = 99,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic [9:0]  head_x,
  input  logic [9:0]  head_y,
  output logic [9:0]  length,
  output logic [9:0]  x_apple,
  output logic [9:0]  y_apple,
  output logic        apple_valid,
  output logic        eaten,
  output logic [15:0] score
);
  typedef enum logic [1:0] {ARMED, EAT, SPAWN} state_e;

  localparam logic [9:0]  X_MIN  = 10'(2*GRID);
  localparam logic [9:0]  X_MAX  = 10'(SCREEN_W-3*GRID);
  localparam logic [9:0]  Y_MIN  = 10'(2*GRID);
  localparam logic [9:0]  Y_MAX  = 10'(SCREEN_H-3*GRID);
  localparam logic [10:0] GRID_W = 11'(GRID);
  localparam logic [9:0]  LEN_MAX = 10'(MAX_LENGTH);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [9:0]  length_q, x_q, y_q;
  logic [15:0] score_q;
  logic        valid_q, eaten_q;

  logic [9:0]  cand_x, cand_y;
  logic [10:0] dx, dy, adx, ady;
  logic        accept, hit;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign cand_x = lfsr_q[9:0];
  assign cand_y = {1'b0, lfsr_q[15:7]};

  // Zero-extended 11-bit differences; the magnitude always fits in 11 bits.
  assign dx  = {1'b0, head_x} - {1'b0, x_q};
  assign dy  = {1'b0, head_y} - {1'b0, y_q};
  assign adx = dx[10] ? (~dx + 11'd1) : dx;
  assign ady = dy[10] ? (~dy + 11'd1) : dy;
  assign hit = (adx < GRID_W) && (ady < GRID_W);

  always_comb begin
    accept = (cand_x >= X_MIN) && (cand_x <= X_MAX) &&
             (cand_y >= Y_MIN) && (cand_y <= Y_MAX);
`ifdef APPLE_KEEPOUT_EN
    if ((cand_x >= 10'd160) && (cand_x <= 10'd480) &&
        (cand_y >= 10'd180) && (cand_y <= 10'd300))
      accept = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED:   if (tick && hit) state_d = EAT;
      EAT:     state_d = SPAWN;
      SPAWN:   if (accept) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  // valid/eaten are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ARMED;
      lfsr_q   <= LFSR_SEED;
      length_q <= 10'(INIT_LENGTH);
      score_q  <= '0;
      x_q      <= 10'd480;
      y_q      <= 10'd360;
      valid_q  <= 1'b1;
      eaten_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      valid_q <= (state_d == ARMED);
      eaten_q <= (state_d == EAT);
      if (state_q == EAT) begin
        score_q <= score_q + 16'd1;
        if (length_q < LEN_MAX) length_q <= length_q + 10'd1;
      end
      if (state_q == SPAWN && accept) begin
        x_q <= cand_x;
        y_q <= cand_y;
      end
    end
  end

  assign length      = length_q;
  assign x_apple     = x_q;
  assign y_apple     = y_q;
  assign apple_valid = valid_q;
  assign eaten       = eaten_q;
  assign score       = score_q;
endmodule
